priority_demux: RTL and testbench

//  Splits one valid/ready input stream across OUTPUTS output lanes; each word goes to the

---
 rtl/priority_demux.sv | 100 ++++++++++
 tb/tb_priority_demux.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/priority_demux.sv
// priority_demux: routes one valid/ready input stream to OUTPUTS lanes.
// Each word goes to the lowest-index lane that is both selected by i_sel and
// free (empty, or draining this cycle). Each lane owns a one-entry registered
// output buffer. A word with an all-zero i_sel is accepted and discarded.
// Optional feature macro: PRIORITY_DEMUX_STATS_EN adds accept/drop counters.
module priority_demux #(
  parameter int OUTPUTS = 19,
  parameter int WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  output logic                              i_ready,
  input  logic [OUTPUTS-1:0]                i_sel,
  input  logic [WIDTH-1:0]                  i_data,
  output logic [OUTPUTS-1:0]                o_valid,
  input  logic [OUTPUTS-1:0]                o_ready,
`ifdef PRIORITY_DEMUX_STATS_EN
  output logic [OUTPUTS-1:0][WIDTH-1:0]     o_data,
  output logic [31:0]                       o_accept_cnt,
  output logic [31:0]                       o_drop_cnt
`else
  output logic [OUTPUTS-1:0][WIDTH-1:0]     o_data
`endif
);

  // A lane can take a word if it is empty or its current word leaves this cycle.
  logic [OUTPUTS-1:0] free_lane;
  logic [OUTPUTS-1:0] eligible;
  logic [OUTPUTS-1:0] grant;
  logic [OUTPUTS-1:0] load;
  logic               sel_none;
  logic               routed;

  assign free_lane = ~o_valid | o_ready;
  assign eligible  = i_sel & free_lane;
  assign sel_none  = (i_sel == '0);
  assign i_ready   = (|eligible) | sel_none;
  assign routed    = i_valid & (|eligible);
  assign load      = grant & {OUTPUTS{i_valid}};

  // Lowest-index eligible lane wins; at most one grant bit is set.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < OUTPUTS; k++) begin
      if (eligible[k] && !found) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // One output buffer per lane; data holds after drain, reload beats drain.
  for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_lane
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // Lane buffer: reset clears, load fills, consumer handshake empties.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else if (load[gi]) begin
        valid_reg <= 1'b1;
        data_reg  <= i_data;
      end else if (o_ready[gi]) begin
        valid_reg <= 1'b0;
      end
    end

    assign o_valid[gi] = valid_reg;
    assign o_data[gi]  = data_reg;
  end

`ifdef PRIORITY_DEMUX_STATS_EN
  logic [31:0] accept_cnt_reg;
  logic [31:0] drop_cnt_reg;

  // Counters wrap naturally at 2^32; a dropped word is an accepted all-zero-select word.
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt_reg <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      if (routed) begin
        accept_cnt_reg <= accept_cnt_reg + 32'd1;
      end
      if (i_valid && sel_none) begin
        drop_cnt_reg <= drop_cnt_reg + 32'd1;
      end
    end
  end

  assign o_accept_cnt = accept_cnt_reg;
  assign o_drop_cnt   = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_priority_demux.sv
// Testbench for priority_demux: directed vectors with literal expectations plus
// a lane-state model checked against the DUT every cycle, then random traffic.
module tb_priority_demux;
  localparam int N = 19;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic             i_ready;
  logic [N-1:0]     i_sel;
  logic [W-1:0]     i_data;
  logic [N-1:0]     o_valid;
  logic [N-1:0]     o_ready;
  logic [N-1:0][W-1:0] o_data;
`ifdef PRIORITY_DEMUX_STATS_EN
  logic [31:0]      o_accept_cnt;
  logic [31:0]      o_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  priority_demux #(.OUTPUTS(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_sel   (i_sel),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
`ifdef PRIORITY_DEMUX_STATS_EN
    .o_data       (o_data),
    .o_accept_cnt (o_accept_cnt),
    .o_drop_cnt   (o_drop_cnt)
`else
    .o_data  (o_data)
`endif
  );

  // ---------------- behavioural model ----------------
  logic [N-1:0]        m_valid = '0;
  logic [N-1:0][W-1:0] m_data  = '0;
  logic [31:0]         m_acc   = '0;
  logic [31:0]         m_drop  = '0;
  bit                  m_known = 1'b0;

  // Lowest lane that is selected and either empty or being drained; -1 if none.
  function automatic int pick_lane(input logic [N-1:0] sel, input logic [N-1:0] full,
                                   input logic [N-1:0] rdy);
    for (int k = 0; k < N; k++) begin
      if (sel[k] && (!full[k] || rdy[k])) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= '0;
      m_data  <= '0;
      m_acc   <= '0;
      m_drop  <= '0;
      m_known <= 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_valid[k] && o_ready[k]) m_valid[k] <= 1'b0;
      end
      if (i_valid && i_sel == '0) begin
        m_drop <= m_drop + 32'd1;
      end else if (i_valid && pick_lane(i_sel, m_valid, o_ready) >= 0) begin
        m_valid[pick_lane(i_sel, m_valid, o_ready)] <= 1'b1;
        m_data[pick_lane(i_sel, m_valid, o_ready)]  <= i_data;
        m_acc <= m_acc + 32'd1;
      end
    end
  end

  // Compare process: outputs and i_ready against the model on the falling edge.
  always @(negedge clk) begin
    if (m_known) begin
      logic exp_ready;
      exp_ready = (pick_lane(i_sel, m_valid, o_ready) >= 0) || (i_sel == '0);
      checks++;
      if (i_ready !== exp_ready) begin
        errors++;
        $display("FAIL model_i_ready t=%0t got=%b exp=%b", $time, i_ready, exp_ready);
      end
      checks++;
      if (o_valid !== m_valid) begin
        errors++;
        $display("FAIL model_o_valid t=%0t got=%h exp=%h", $time, o_valid, m_valid);
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (o_data[k] !== m_data[k]) begin
          errors++;
          $display("FAIL model_o_data[%0d] t=%0t got=%h exp=%h", k, $time, o_data[k], m_data[k]);
        end
      end
`ifdef PRIORITY_DEMUX_STATS_EN
      checks++;
      if (o_accept_cnt !== m_acc || o_drop_cnt !== m_drop) begin
        errors++;
        $display("FAIL model_counters t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                 o_accept_cnt, o_drop_cnt, m_acc, m_drop);
      end
`endif
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_sel = '0; i_data = '0; o_ready = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_o_valid", W'(o_valid), 32'h0);
    chk("reset_o_data0", o_data[0], 32'h0);
    chk("reset_o_data18", o_data[18], 32'h0);
`ifdef PRIORITY_DEMUX_STATS_EN
    chk("reset_cnts", o_accept_cnt | o_drop_cnt, 32'h0);
`endif

    // Priority: lane1 wins over lane2
    i_valid = 1'b1; i_sel = 19'b0110; i_data = 32'hA5A5A5A5; #1;
    chk("prio_i_ready", W'(i_ready), 32'h1);
    cyc(); i_valid = 1'b0;
    chk("prio_o_valid", W'(o_valid), 32'h2);
    chk("prio_o_data1", o_data[1], 32'hA5A5A5A5);

    // Fallback: lane1 full and stalled, word goes to lane2
    i_valid = 1'b1; i_sel = 19'b0110; i_data = 32'h11;
    cyc(); i_valid = 1'b0;
    chk("fb_o_valid", W'(o_valid), 32'h6);
    chk("fb_o_data2", o_data[2], 32'h11);
    chk("fb_o_data1_hold", o_data[1], 32'hA5A5A5A5);

    // Stall then same-cycle drain and refill on lane2
    i_valid = 1'b1; i_sel = 19'b0110; i_data = 32'h22; #1;
    chk("stall_i_ready", W'(i_ready), 32'h0);
    cyc();
    chk("stall_o_data2_hold", o_data[2], 32'h11);
    o_ready = 19'b0100; #1;
    chk("refill_i_ready", W'(i_ready), 32'h1);
    cyc(); o_ready = '0; i_valid = 1'b0;
    chk("refill_o_valid", W'(o_valid), 32'h6);
    chk("refill_o_data2", o_data[2], 32'h22);

    // Drop: empty select for three cycles, even with selected lanes full
    i_valid = 1'b1; i_sel = '0; i_data = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("drop_i_ready", W'(i_ready), 32'h1);
      cyc();
    end
    i_valid = 1'b0;
    chk("drop_o_valid", W'(o_valid), 32'h6);
`ifdef PRIORITY_DEMUX_STATS_EN
    chk("drop_cnt", o_drop_cnt, 32'd3);
    chk("accept_cnt", o_accept_cnt, 32'd3);
`endif

    // Drain everything; data holds after valid drops
    o_ready = '1;
    cyc(); o_ready = '0;
    chk("drain_o_valid", W'(o_valid), 32'h0);
    chk("drain_o_data1_hold", o_data[1], 32'hA5A5A5A5);

    // Reset beats a simultaneous accept
    rst = 1'b1; i_valid = 1'b1; i_sel = 19'b1; i_data = 32'h33;
    cyc(); rst = 1'b0; i_valid = 1'b0;
    chk("rst_prio_o_valid", W'(o_valid), 32'h0);
    chk("rst_prio_o_data0", o_data[0], 32'h0);
    chk("rst_prio_o_data1", o_data[1], 32'h0);

    // Random traffic, checked every cycle by the model compare process
    for (int c = 0; c < 10000; c++) begin
      rst     = ($urandom_range(0, 999) == 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_sel   = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom & $urandom & $urandom);
      i_data  = $urandom;
      o_ready = N'($urandom | $urandom);
      if ($urandom_range(0, 3) == 0) o_ready = '0;
      cyc();
    end
    rst = 1'b0; i_valid = 1'b0; o_ready = '0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
